// File: rtl/maple_pkg.sv
// Shared types and constants for the Maple Bus transaction sequencer.
package maple_pkg;

  localparam int C_TIMEOUT_WIDTH_DEF = 20;
  localparam int C_TURN_WIDTH_DEF    = 8;
  localparam int C_TX_GUARD_DEF      = 16;
  localparam int TXN_W               = 16;

  typedef enum logic [2:0] {
    IDLE,
    TX_START,
    TX_ACTIVE,
    TURNAROUND,
    RX_WAIT,
    RX_ACTIVE,
    DONE
  } state_t;

  localparam logic [2:0] ST_NONE     = 3'd0;
  localparam logic [2:0] ST_OK       = 3'd1;
  localparam logic [2:0] ST_TIMEOUT  = 3'd2;
  localparam logic [2:0] ST_TX_FAULT = 3'd3;
  localparam logic [2:0] ST_ABORT    = 3'd4;
  localparam logic [2:0] ST_REJECT   = 3'd5;

endpackage

// File: rtl/maple_down_counter.sv
// Loadable down counter that stops at zero; load wins over decrement.
module maple_down_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && !zero) begin
      count <= count - W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/maple_bus_sequencer.sv
// Runs one Maple Bus transaction per start: TX, bus turnaround, RX with timeout.
// All outputs are registered from the next state, so they track the state register.
module maple_bus_sequencer
  import maple_pkg::*;
#(
  parameter int C_TIMEOUT_WIDTH = C_TIMEOUT_WIDTH_DEF,
  parameter int C_TURN_WIDTH    = C_TURN_WIDTH_DEF,
  parameter int C_TX_GUARD      = C_TX_GUARD_DEF
) (
  input  logic                       aclk,
  input  logic                       aresetn,
  input  logic                       start,
  input  logic                       abort,
  input  logic                       tx_pkt_ready,
  input  logic                       transmitting,
  input  logic                       receiving,
  input  logic [C_TURN_WIDTH-1:0]    turnaround_cycles,
  input  logic [C_TIMEOUT_WIDTH-1:0] rx_timeout_cycles,
  output logic                       tx_enable,
  output logic                       rx_enable,
  output logic                       drive_en,
  output logic                       busy,
  output logic                       done,
  output logic [2:0]                 status,
  output logic [TXN_W-1:0]           txn_count
);

  localparam int GW = $clog2(C_TX_GUARD) + 1;
  localparam int CW = (C_TURN_WIDTH > GW) ? C_TURN_WIDTH : GW;
  localparam logic [CW-1:0] GUARD_LOAD = CW'(C_TX_GUARD - 1);

  state_t                     state, next_state;
  logic [C_TURN_WIDTH-1:0]    turn_q, turn_len;
  logic [C_TIMEOUT_WIDTH-1:0] tmo_q;
  logic [2:0]                 status_nxt;
  logic                       txn_ok;
  logic [TXN_W-1:0]           txn_inc;
  logic                       accept, reject;
  logic                       tx_nxt, rx_nxt, drive_nxt, busy_nxt, done_nxt;
  logic                       ph_load, ph_dec, ph_zero;
  logic [CW-1:0]              ph_load_val;
  logic                       tm_load, tm_dec, tm_zero;

  assign accept  = (state == IDLE) && start && tx_pkt_ready;
  assign reject  = (state == IDLE) && start && !tx_pkt_ready;
  assign txn_inc = txn_count + TXN_W'(1);

  // A zero turnaround still releases the bus for one cycle.
  assign turn_len    = (turn_q == '0) ? C_TURN_WIDTH'(1) : turn_q;
  assign ph_load     = (next_state != state) &&
                       ((next_state == TX_START) || (next_state == TURNAROUND));
  assign ph_load_val = (next_state == TX_START) ? GUARD_LOAD
                                                : CW'(turn_len - C_TURN_WIDTH'(1));
  assign ph_dec      = (state == TX_START) || (state == TURNAROUND);
  assign tm_load     = (next_state == RX_WAIT) && (state != RX_WAIT);
  assign tm_dec      = (state == RX_WAIT);

  maple_down_counter #(.W(CW)) u_phase_cnt (
    .clk      (aclk),
    .rst_n    (aresetn),
    .load     (ph_load),
    .load_val (ph_load_val),
    .dec      (ph_dec),
    .zero     (ph_zero)
  );

  maple_down_counter #(.W(C_TIMEOUT_WIDTH)) u_timeout_cnt (
    .clk      (aclk),
    .rst_n    (aresetn),
    .load     (tm_load),
    .load_val (tmo_q - C_TIMEOUT_WIDTH'(1)),
    .dec      (tm_dec),
    .zero     (tm_zero)
  );

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state     <= IDLE;
      tx_enable <= 1'b0;
      rx_enable <= 1'b0;
      drive_en  <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      status    <= ST_NONE;
      txn_count <= '0;
      turn_q    <= '0;
      tmo_q     <= '0;
    end else begin
      state     <= next_state;
      tx_enable <= tx_nxt;
      rx_enable <= rx_nxt;
      drive_en  <= drive_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
      status    <= status_nxt;
      if (txn_ok) txn_count <= txn_inc;
      if (accept) begin
        turn_q <= turnaround_cycles;
        tmo_q  <= rx_timeout_cycles;
      end
    end
  end

  always_comb begin
    next_state = state;
    status_nxt = status;
    txn_ok     = 1'b0;
    if ((state != IDLE) && abort) begin
      next_state = DONE;
      status_nxt = ST_ABORT;
    end else begin
      case (state)
        IDLE: begin
          if (accept) next_state = TX_START;
          else if (reject) status_nxt = ST_REJECT;
        end
        TX_START: begin
          if (transmitting) begin
            next_state = TX_ACTIVE;
          end else if (ph_zero) begin
            next_state = DONE;
            status_nxt = ST_TX_FAULT;
          end
        end
        TX_ACTIVE:  if (!transmitting) next_state = TURNAROUND;
        TURNAROUND: if (ph_zero) next_state = RX_WAIT;
        RX_WAIT: begin
          // A response arriving on the expiry cycle takes precedence.
          if (receiving) begin
            next_state = RX_ACTIVE;
          end else if ((tmo_q != '0) && tm_zero) begin
            next_state = DONE;
            status_nxt = ST_TIMEOUT;
          end
        end
        RX_ACTIVE: begin
          if (!receiving) begin
            next_state = DONE;
            status_nxt = ST_OK;
            txn_ok     = 1'b1;
          end
        end
        DONE:    next_state = IDLE;
        default: next_state = IDLE;
      endcase
    end
  end

  always_comb begin
    tx_nxt    = (next_state == TX_START) || (next_state == TX_ACTIVE);
    rx_nxt    = (next_state == RX_WAIT) || (next_state == RX_ACTIVE);
    drive_nxt = !((next_state == TURNAROUND) || rx_nxt);
    busy_nxt  = (next_state != IDLE);
    done_nxt  = (next_state == DONE) || reject;
  end

endmodule

// File: tb/tb_maple_bus_sequencer.sv
// Directed bench: each transaction's phase boundaries are derived arithmetically and every cycle is compared.
module tb_maple_bus_sequencer;

  localparam int GUARD = 16;
  localparam int INF   = 1 << 30;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b1;
  logic        start = 1'b0, abort = 1'b0, tx_pkt_ready = 1'b0;
  logic        transmitting = 1'b0, receiving = 1'b0;
  logic [7:0]  turnaround_cycles = '0;
  logic [19:0] rx_timeout_cycles = '0;
  logic        tx_enable, rx_enable, drive_en, busy, done;
  logic [2:0]  status;
  logic [15:0] txn_count;

  int checks = 0;
  int errors = 0;

  logic        e_tx, e_rx, e_drv, e_busy, e_done;
  logic [2:0]  e_status;
  logic [15:0] e_txn;
  bit          chk_en = 1'b0;
  int          n_turn, n_tx, n_rx;
  logic [2:0]  m_status = 3'd0;
  logic [15:0] m_txn = 16'd0;

  always #5 aclk = ~aclk;

  maple_bus_sequencer dut (
    .aclk              (aclk),
    .aresetn           (aresetn),
    .start             (start),
    .abort             (abort),
    .tx_pkt_ready      (tx_pkt_ready),
    .transmitting      (transmitting),
    .receiving         (receiving),
    .turnaround_cycles (turnaround_cycles),
    .rx_timeout_cycles (rx_timeout_cycles),
    .tx_enable         (tx_enable),
    .rx_enable         (rx_enable),
    .drive_en          (drive_en),
    .busy              (busy),
    .done              (done),
    .status            (status),
    .txn_count         (txn_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  always @(negedge aclk) begin
    if (chk_en) begin
      chk("tx_enable", 32'(tx_enable), 32'(e_tx));
      chk("rx_enable", 32'(rx_enable), 32'(e_rx));
      chk("drive_en",  32'(drive_en),  32'(e_drv));
      chk("busy",      32'(busy),      32'(e_busy));
      chk("done",      32'(done),      32'(e_done));
      chk("status",    32'(status),    32'(e_status));
      chk("txn_count", 32'(txn_count), 32'(e_txn));
      if (busy && !drive_en && !rx_enable) n_turn++;
      if (tx_enable) n_tx++;
      if (rx_enable) n_rx++;
    end
  end

  // ab_base: 0 none, 1 relative to RX_WAIT entry, 2 relative to receiving rise, 3 absolute cycle.
  task automatic run_txn(input bit ready, input int a, input int len, input int turn,
                         input int rxd, input int rlen, input int tmo,
                         input int ab_base, input int ab_rel, input bit chg, input bit ovr,
                         output int d_out);
    int tx_stop, t0, r0, b, d, ab, tl;
    logic [2:0]  st;
    logic [15:0] new_txn;
    tl = (turn == 0) ? 1 : turn;
    tx_stop = INF; t0 = INF; r0 = INF; b = INF; d = INF; st = m_status;
    if (!ready) begin
      d = 1; st = 3'd5;
    end else if (a >= 1 && a <= GUARD) begin
      tx_stop = a + len + 1;
      t0 = tx_stop;
      r0 = t0 + tl;
      if (rxd >= 0 && (tmo == 0 || rxd < tmo)) begin
        b = r0 + rxd; d = b + rlen + 1; st = 3'd1;
      end else if (tmo != 0) begin
        d = r0 + tmo; st = 3'd2;
      end
    end else begin
      tx_stop = GUARD + 1; d = GUARD + 1; st = 3'd3;
    end
    case (ab_base)
      1:       ab = r0 + ab_rel;
      2:       ab = b + ab_rel;
      3:       ab = ab_rel;
      default: ab = INF;
    endcase
    if (ready && ab >= 1 && ab < d) begin
      d = ab + 1; st = 3'd4;
    end
    new_txn = (st == 3'd1) ? (ovr ? 16'hFFFF : 16'(m_txn + 16'd1)) : m_txn;
    n_turn = 0; n_tx = 0; n_rx = 0;
    for (int c = 0; c <= d + 2; c++) begin
      @(posedge aclk); #1;
      start             = (c == 0);
      tx_pkt_ready      = ready;
      transmitting      = (a >= 0) && (c >= a) && (c < a + len);
      receiving         = (c >= b) && (c < b + rlen);
      abort             = (c == ab);
      turnaround_cycles = (c > 0 && chg) ? 8'd50 : 8'(turn);
      rx_timeout_cycles = (c > 0 && chg) ? 20'd2 : 20'(tmo);
      e_tx     = ready && (c >= 1) && (c < ((tx_stop < d) ? tx_stop : d));
      e_drv    = !((c >= ((t0 < d) ? t0 : d)) && (c < d));
      e_rx     = (c >= ((r0 < d) ? r0 : d)) && (c < d);
      e_busy   = ready && (c >= 1) && (c <= d);
      e_done   = (c == d);
      e_status = (c >= d) ? st : m_status;
      e_txn    = (c >= d) ? new_txn : m_txn;
      chk_en   = 1'b1;
    end
    @(posedge aclk); #1;
    chk_en = 1'b0;
    start = 1'b0; abort = 1'b0; transmitting = 1'b0; receiving = 1'b0; tx_pkt_ready = 1'b0;
    m_status = st;
    m_txn = new_txn;
    d_out = d;
  endtask

  initial begin
    int d;
    #2 aresetn = 1'b0;
    #1;
    chk("rst_tx",     32'(tx_enable), 32'd0);
    chk("rst_rx",     32'(rx_enable), 32'd0);
    chk("rst_drive",  32'(drive_en),  32'd1);
    chk("rst_busy",   32'(busy),      32'd0);
    chk("rst_done",   32'(done),      32'd0);
    chk("rst_status", 32'(status),    32'd0);
    chk("rst_count",  32'(txn_count), 32'd0);
    repeat (3) @(posedge aclk);
    @(negedge aclk) aresetn = 1'b1;

    // normal transaction
    run_txn(1, 3, 40, 5, 10, 30, 1000, 0, 0, 0, 0, d);
    chk("normal_len",    32'(d),         32'd90);
    chk("normal_turn",   32'(n_turn),    32'd5);
    chk("normal_status", 32'(status),    32'd1);
    chk("normal_count",  32'(txn_count), 32'd1);

    // zero turnaround still gives one release cycle
    run_txn(1, 2, 3, 0, 0, 2, 0, 0, 0, 0, 0, d);
    chk("turn0_len",  32'(d),      32'd10);
    chk("turn0_turn", 32'(n_turn), 32'd1);

    // response timeout
    run_txn(1, 1, 4, 2, -1, 0, 100, 0, 0, 0, 0, d);
    chk("tmo_len",    32'(d),         32'd108);
    chk("tmo_rxcyc",  32'(n_rx),      32'd100);
    chk("tmo_status", 32'(status),    32'd2);
    chk("tmo_rx_off", 32'(rx_enable), 32'd0);
    chk("tmo_drive",  32'(drive_en),  32'd1);

    // transmitter never starts
    run_txn(1, -1, 0, 1, -1, 0, 0, 0, 0, 0, 0, d);
    chk("fault_len",    32'(d),         32'd17);
    chk("fault_txcyc",  32'(n_tx),      32'd16);
    chk("fault_status", 32'(status),    32'd3);
    chk("fault_tx_off", 32'(tx_enable), 32'd0);

    // start with empty FIFO
    run_txn(0, -1, 0, 1, -1, 0, 0, 0, 0, 0, 0, d);
    chk("reject_status", 32'(status), 32'd5);
    chk("reject_txcyc",  32'(n_tx),   32'd0);

    // abort in RX_ACTIVE
    run_txn(1, 1, 2, 3, 4, 20, 50, 2, 5, 0, 0, d);
    chk("abort_len",    32'(d),         32'd17);
    chk("abort_status", 32'(status),    32'd4);
    chk("abort_count",  32'(txn_count), 32'd2);

    // no timeout: 10000 cycles of waiting, then abort
    run_txn(1, 1, 1, 1, -1, 0, 0, 1, 10000, 0, 0, d);
    chk("notmo_rxcyc", 32'(n_rx), 32'd10001);

    // parameters latched at start, later input changes ignored
    run_txn(1, 2, 2, 3, -1, 0, 20, 0, 0, 1, 0, d);
    chk("latch_len",  32'(d),      32'd28);
    chk("latch_turn", 32'(n_turn), 32'd3);

    // receiving on the expiry cycle wins; abort with start in IDLE is ignored
    run_txn(1, 1, 1, 1, 5, 3, 6, 3, 0, 0, 0, d);
    chk("edge_len",    32'(d),      32'd13);
    chk("edge_status", 32'(status), 32'd1);

    // transmitting rises on the last guard cycle
    run_txn(1, 16, 1, 1, 0, 1, 0, 0, 0, 0, 0, d);
    chk("guard_len",   32'(d),         32'd21);
    chk("guard_count", 32'(txn_count), 32'd4);

    // reset in the middle of TX_ACTIVE
    @(posedge aclk); #1;
    start = 1'b1; tx_pkt_ready = 1'b1; turnaround_cycles = 8'd5;
    @(posedge aclk); #1;
    start = 1'b0; transmitting = 1'b1;
    repeat (4) @(posedge aclk);
    #1;
    chk("mid_tx_on",   32'(tx_enable), 32'd1);
    chk("mid_busy_on", 32'(busy),      32'd1);
    #2 aresetn = 1'b0;
    #1;
    chk("arst_tx",     32'(tx_enable), 32'd0);
    chk("arst_rx",     32'(rx_enable), 32'd0);
    chk("arst_drive",  32'(drive_en),  32'd1);
    chk("arst_busy",   32'(busy),      32'd0);
    chk("arst_done",   32'(done),      32'd0);
    chk("arst_status", 32'(status),    32'd0);
    chk("arst_count",  32'(txn_count), 32'd0);
    transmitting = 1'b0; tx_pkt_ready = 1'b0;
    @(negedge aclk) aresetn = 1'b1;
    m_status = 3'd0;
    m_txn = 16'd0;

    // counter wrap: land on 0xFFFF, then one more completion
    force dut.txn_inc = 16'hFFFF;
    run_txn(1, 1, 2, 1, 1, 2, 0, 0, 0, 0, 1, d);
    chk("wrap_preload", 32'(txn_count), 32'h0000FFFF);
    release dut.txn_inc;
    run_txn(1, 1, 2, 1, 1, 2, 0, 0, 0, 0, 0, d);
    chk("wrap_zero", 32'(txn_count), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/maple_bus_sequencer.md
Name: maple_bus_sequencer

Overview:
- Host-side transaction sequencer for the Maple Bus datapath; sits between the AXI-Lite control registers and the transmitter/receiver pair.
- Runs one complete bus transaction per start command: enable the transmitter, wait for the packet to finish, release the bus for a programmable turnaround, then enable the receiver and wait for the response.
- Enforces a response timeout and handles abort.
- Reports status, a transaction counter and one-cycle completion pulses.

Parameters:
- C_TIMEOUT_WIDTH, 20, width of the response-timeout counter and of rx_timeout_cycles.
- C_TURN_WIDTH, 8, width of the turnaround counter and of turnaround_cycles.
- C_TX_GUARD, 16, maximum cycles from tx_enable assertion to transmitting rising before a TX fault.

Ports:
- aclk  in  1  system clock
- aresetn  in  1  asynchronous active-low reset
- start  in  1  one-cycle command pulse from the control register
- abort  in  1  one-cycle abort pulse
- tx_pkt_ready  in  1  TX FIFO holds data (m_axis tvalid)
- transmitting  in  1  transmitter busy
- receiving  in  1  receiver detected packet, busy
- turnaround_cycles  in  C_TURN_WIDTH  bus release delay
- rx_timeout_cycles  in  C_TIMEOUT_WIDTH  response wait limit; 0 = no timeout
- tx_enable  out  1  transmitter enable
- rx_enable  out  1  receiver enable
- drive_en  out  1  1 = host drives sdcka/sdckb; 0 = tristate
- busy  out  1  transaction in progress
- done  out  1  one-cycle pulse at transaction end (any outcome)
- status  out  3  last outcome code
- txn_count  out  16  completed OK transactions, wraps

Behaviour:
- Clock and reset: one clock, aclk. Reset is asynchronous and active-low on aresetn; all state is cleared immediately on assertion.
- Reset values: state IDLE; tx_enable=0; rx_enable=0; drive_en=1; busy=0; done=0; status=0; txn_count=0; counters 0.
- Status codes: 0 none, 1 OK, 2 RX timeout, 3 TX fault, 4 aborted, 5 start rejected (FIFO empty).
- States: IDLE, TX_START, TX_ACTIVE, TURNAROUND, RX_WAIT, RX_ACTIVE, DONE.
- IDLE:
  - start with tx_pkt_ready=1 moves to TX_START next cycle.
  - On acceptance, latch turnaround_cycles and rx_timeout_cycles; later changes to the inputs are ignored for the current transaction.
  - start with tx_pkt_ready=0: stay in IDLE, status=5, done pulse.
  - start while busy=1 is ignored (no status change).
- TX_START:
  - tx_enable=1, drive_en=1, guard counter runs.
  - transmitting=1 moves to TX_ACTIVE.
  - After C_TX_GUARD cycles without transmitting, go to DONE with status 3.
- TX_ACTIVE:
  - tx_enable=1.
  - Falling edge of transmitting (sampled 1 then 0) moves to TURNAROUND; tx_enable drops on the same edge.
- TURNAROUND:
  - drive_en=0, tx_enable=0, rx_enable=0.
  - Lasts max(latched turnaround_cycles, 1) cycles, then RX_WAIT.
- RX_WAIT:
  - rx_enable=1, drive_en=0.
  - receiving=1 moves to RX_ACTIVE.
  - If the latched timeout ≠ 0 and the timer reaches the latched value, go to DONE with status 2.
  - If receiving rises on the same cycle the timeout expires, receiving wins.
- RX_ACTIVE:
  - rx_enable=1, timer stopped.
  - receiving falls: go to DONE with status 1 and increment txn_count (16-bit wrap, 0xFFFF→0x0000).
- DONE:
  - One cycle: done=1, rx_enable=0, drive_en=1, then IDLE.
  - busy=1 in every state except IDLE.
- abort:
  - Takes priority over every other transition in any non-IDLE state.
  - Next cycle: state DONE, tx_enable=0, rx_enable=0, drive_en=1, status=4.
  - abort in IDLE has no effect.
- start and abort on the same cycle in IDLE: start is processed.
- Outputs are registered; tx_enable rises one cycle after start is sampled.

Decomposition:
- Shared package maple_pkg holds:
  - the state encoding enum;
  - the status code constants (ST_NONE..ST_REJECT);
  - default widths.
- One natural sub-module: maple_down_counter, a loadable down counter with zero flag. It is instantiated for the guard/turnaround counters and for the timeout timer.

Test Plan:
- Normal transaction: tx_pkt_ready=1, start; transmitting high 40 cycles, turnaround_cycles=5, receiving high 30 cycles starting 10 cycles into RX_WAIT -> drive_en low exactly 5 cycles before rx_enable; done pulse; status=1; txn_count=1.
- Timeout: rx_timeout_cycles=100, receiving never rises -> done 100 cycles after RX_WAIT entry; status=2; rx_enable=0, drive_en=1 after DONE.
- TX fault: transmitting held 0 after start -> status=3 after 16 cycles; tx_enable deasserted.
- Abort mid-RX_ACTIVE -> next cycle all enables low, drive_en=1, status=4, txn_count unchanged. Also assert aresetn=0 mid-TX_ACTIVE -> outputs return to reset values immediately.
- Edge cases:
  - start with tx_pkt_ready=0 -> status=5, no tx_enable.
  - turnaround_cycles=0 -> TURNAROUND lasts 1 cycle.
  - rx_timeout_cycles=0 -> waits 10000 cycles without timeout.
  - Preload 0xFFFF transactions -> txn_count wraps to 0.
